// File: rtl/sram_dp_param.sv
// Parametrised true dual-port SRAM model: byte enables, 1/2-cycle read pipeline, collision flag.
// Define SRAM_DP_CLEAR_EN to include the post-reset zeroing sequencer.
module sram_dp_param #(
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_en,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                collision,
  output logic                init_done
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic init_ok;
  logic a_in, b_in, a_wr, b_wr, a_rd, b_rd;

  assign a_in = ({1'b0, a_addr} < DepthL);
  assign b_in = ({1'b0, b_addr} < DepthL);
  assign a_wr = a_en & init_ok & a_we & a_in;
  assign b_wr = b_en & init_ok & b_we & b_in;
  assign a_rd = a_en & init_ok & ~a_we;
  assign b_rd = b_en & init_ok & ~b_we;

`ifdef SRAM_DP_CLEAR_EN
  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        state_d = StClear;
        ptr_d   = '0;
      end
      StClear: begin
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = StDone;
        else                             ptr_d   = ptr_q + ADDR_W'(1);
      end
      StDone: ;
      default: state_d = StClear;
    endcase
  end

  assign init_ok = (state_q == StDone);
`else
  assign init_ok = 1'b1;
`endif

  assign init_done = init_ok;

  // Port A is applied last so its enabled bytes win a same-address write collision.
  always_ff @(posedge clk) begin
`ifdef SRAM_DP_CLEAR_EN
    if (state_q == StClear) mem[ptr_q] <= '0;
`endif
    for (int k = 0; k < BE_W; k++) begin
      if (b_wr && b_be[k]) mem[b_addr][8*k +: 8] <= b_wdata[8*k +: 8];
      if (a_wr && a_be[k]) mem[a_addr][8*k +: 8] <= a_wdata[8*k +: 8];
    end
  end

  logic [DATA_W-1:0] a_rd_q, b_rd_q;
  logic              a_rv_q, b_rv_q, coll_q;

  // Reads sample the array before this edge's writes land, giving read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rv_q <= 1'b0;
      b_rv_q <= 1'b0;
      a_rd_q <= '0;
      b_rd_q <= '0;
      coll_q <= 1'b0;
    end else begin
      a_rv_q <= a_rd;
      b_rv_q <= b_rd;
      if (a_rd) a_rd_q <= a_in ? mem[a_addr] : '0;
      if (b_rd) b_rd_q <= b_in ? mem[b_addr] : '0;
      coll_q <= a_wr & b_wr & (a_addr == b_addr);
    end
  end

  assign collision = coll_q;

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] a_out_q, b_out_q;
    logic              a_ov_q, b_ov_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_ov_q  <= 1'b0;
        b_ov_q  <= 1'b0;
        a_out_q <= '0;
        b_out_q <= '0;
      end else begin
        a_ov_q <= a_rv_q;
        b_ov_q <= b_rv_q;
        if (a_rv_q) a_out_q <= a_rd_q;
        if (b_rv_q) b_out_q <= b_rd_q;
      end
    end

    assign a_rdata  = a_out_q;
    assign b_rdata  = b_out_q;
    assign a_rvalid = a_ov_q;
    assign b_rvalid = b_ov_q;
  end else begin : g_lat1
    assign a_rdata  = a_rd_q;
    assign b_rdata  = b_rd_q;
    assign a_rvalid = a_rv_q;
    assign b_rvalid = b_rv_q;
  end

endmodule

// File: tb/tb_sram_dp_param.sv
// Scoreboard bench for sram_dp_param: u0 uses default shape, u1 uses DEPTH=100, READ_LAT=2.
// Define SRAM_DP_CLEAR_EN to also exercise the clear sequencer.
module tb_sram_dp_param;

  localparam int DW = 512;
  localparam int BW = 64;
  localparam int AW = 7;

  localparam logic [BW-1:0] BeAll = '1;
  localparam logic [BW-1:0] BeLo  = 64'h0000_0000_FFFF_FFFF;
  localparam logic [DW-1:0] Ones  = '1;
  localparam logic [DW-1:0] ExpBe = {{504{1'b1}}, 8'h00};
  localparam logic [DW-1:0] PatAa = {64{8'hAA}};
  localparam logic [DW-1:0] Pat55 = {64{8'h55}};
  localparam logic [DW-1:0] ExpC  = {{32{8'h55}}, {32{8'hAA}}};
  localparam logic [DW-1:0] PatEe = {64{8'hEE}};
  localparam logic [DW-1:0] ExpC1 = {{63{8'hEE}}, 8'h11};
  localparam logic [DW-1:0] H98   = 512'h9898_0098;
  localparam logic [DW-1:0] H99   = 512'h9999_0099;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic          u0_a_en, u0_a_we, u0_b_en, u0_b_we, u1_a_en, u1_a_we, u1_b_en, u1_b_we;
  logic [BW-1:0] u0_a_be, u0_b_be, u1_a_be, u1_b_be;
  logic [AW-1:0] u0_a_addr, u0_b_addr, u1_a_addr, u1_b_addr;
  logic [DW-1:0] u0_a_wdata, u0_b_wdata, u1_a_wdata, u1_b_wdata;
  logic [DW-1:0] u0_a_rdata, u0_b_rdata, u1_a_rdata, u1_b_rdata;
  logic          u0_a_rvalid, u0_b_rvalid, u1_a_rvalid, u1_b_rvalid;
  logic          u0_coll, u1_coll, u0_init, u1_init;

  sram_dp_param u0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(u0_a_en), .a_we(u0_a_we), .a_be(u0_a_be), .a_addr(u0_a_addr),
    .a_wdata(u0_a_wdata), .a_rdata(u0_a_rdata), .a_rvalid(u0_a_rvalid),
    .b_en(u0_b_en), .b_we(u0_b_we), .b_be(u0_b_be), .b_addr(u0_b_addr),
    .b_wdata(u0_b_wdata), .b_rdata(u0_b_rdata), .b_rvalid(u0_b_rvalid),
    .collision(u0_coll), .init_done(u0_init)
  );

  sram_dp_param #(.DEPTH(100), .READ_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(u1_a_en), .a_we(u1_a_we), .a_be(u1_a_be), .a_addr(u1_a_addr),
    .a_wdata(u1_a_wdata), .a_rdata(u1_a_rdata), .a_rvalid(u1_a_rvalid),
    .b_en(u1_b_en), .b_we(u1_b_we), .b_be(u1_b_be), .b_addr(u1_b_addr),
    .b_wdata(u1_b_wdata), .b_rdata(u1_b_rdata), .b_rvalid(u1_b_rvalid),
    .collision(u1_coll), .init_done(u1_init)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];
  int   cq0[$], cq1[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic idle_all();
    u0_a_en = 1'b0; u0_b_en = 1'b0; u1_a_en = 1'b0; u1_b_en = 1'b0;
  endtask

  task automatic drv(input int p, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] d, input logic [BW-1:0] be);
    case (p)
      0: begin u0_a_en = 1; u0_a_we = we; u0_a_addr = addr; u0_a_wdata = d; u0_a_be = be; end
      1: begin u0_b_en = 1; u0_b_we = we; u0_b_addr = addr; u0_b_wdata = d; u0_b_be = be; end
      2: begin u1_a_en = 1; u1_a_we = we; u1_a_addr = addr; u1_a_wdata = d; u1_a_be = be; end
      default: begin
        u1_b_en = 1; u1_b_we = we; u1_b_addr = addr; u1_b_wdata = d; u1_b_be = be;
      end
    endcase
  endtask

  task automatic wr(input int p, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                    input logic [BW-1:0] be);
    drv(p, 1'b1, addr, d, be);
  endtask

  // Expected data is due at the first negedge after READ_LAT capture edges.
  task automatic rd(input int p, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    exp_t e;
    drv(p, 1'b0, addr, '0, '0);
    e.d   = exp;
    e.due = cyc + ((p < 2) ? 1 : 2);
    case (p)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    idle_all();
  endtask

  task automatic flush();
    q0.delete(); q1.delete(); q2.delete(); q3.delete(); cq0.delete(); cq1.delete();
  endtask

  task automatic pop(input int p);
    case (p)
      0: q0.delete(0);
      1: q1.delete(0);
      2: q2.delete(0);
      default: q3.delete(0);
    endcase
  endtask

  task automatic mon(input int p, input logic v, input logic [DW-1:0] d);
    exp_t e;
    int   n;
    case (p)
      0: n = q0.size();
      1: n = q1.size();
      2: n = q2.size();
      default: n = q3.size();
    endcase
    if (n > 0) begin
      case (p)
        0: e = q0[0];
        1: e = q1[0];
        2: e = q2[0];
        default: e = q3[0];
      endcase
    end
    if (v) begin
      checks++;
      if (n == 0) begin
        errors++;
        $display("FAIL rvalid_p%0d unexpected at cycle %0d data %h", p, cyc, d);
      end else begin
        pop(p);
        if (e.d !== d || e.due != cyc) begin
          errors++;
          $display("FAIL rdata_p%0d got %h at cycle %0d want %h at cycle %0d",
                   p, d, cyc, e.d, e.due);
        end
      end
    end else if (n > 0 && e.due < cyc) begin
      checks++;
      errors++;
      $display("FAIL rvalid_p%0d missing got none want pulse at cycle %0d", p, e.due);
      pop(p);
    end
  endtask

  task automatic monc(input int u, input logic v);
    int n;
    int due;
    n   = (u == 0) ? cq0.size() : cq1.size();
    due = 0;
    if (n > 0) due = (u == 0) ? cq0[0] : cq1[0];
    if (v) begin
      checks++;
      if (n == 0 || due != cyc) begin
        errors++;
        $display("FAIL collision_u%0d got pulse at cycle %0d want %0d", u, cyc, due);
      end
      if (n > 0) begin
        if (u == 0) cq0.delete(0);
        else        cq1.delete(0);
      end
    end else if (n > 0 && due < cyc) begin
      checks++;
      errors++;
      $display("FAIL collision_u%0d missing got none want pulse at cycle %0d", u, due);
      if (u == 0) cq0.delete(0);
      else        cq1.delete(0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, u0_a_rvalid, u0_a_rdata);
      mon(1, u0_b_rvalid, u0_b_rdata);
      mon(2, u1_a_rvalid, u1_a_rdata);
      mon(3, u1_b_rvalid, u1_b_rdata);
      monc(0, u0_coll);
      monc(1, u1_coll);
    end
  end

  // Asserts reset immediately, checks outputs cleared asynchronously, releases after a negedge.
  task automatic reset_pulse();
    idle_all();
    rst_n = 1'b0;
    flush();
    #1;
    chk1("rst_u0_a_rvalid", u0_a_rvalid, 1'b0);
    chk1("rst_u0_b_rvalid", u0_b_rvalid, 1'b0);
    chk1("rst_u1_b_rvalid", u1_b_rvalid, 1'b0);
    chk1("rst_u0_coll", u0_coll, 1'b0);
    chk("rst_u0_a_rdata", u0_a_rdata, '0);
    chk("rst_u1_b_rdata", u1_b_rdata, '0);
`ifdef SRAM_DP_CLEAR_EN
    chk1("rst_init_done", u0_init, 1'b0);
`else
    chk1("rst_init_done", u0_init, 1'b1);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef SRAM_DP_CLEAR_EN
  task automatic wait_clear();
    int n0 = -1;
    int n1 = -1;
    for (int i = 1; i <= 300 && n0 < 0; i++) begin
      @(negedge clk);
      if (n1 < 0 && u1_init) n1 = i;
      if (n0 < 0 && u0_init) n0 = i;
    end
    chk("clear_cycles_u0", DW'(n0), DW'(128));
    chk("clear_cycles_u1", DW'(n1), DW'(100));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    idle_all();
    u0_a_we = 0; u0_b_we = 0; u1_a_we = 0; u1_b_we = 0;
    u0_a_be = '0; u0_b_be = '0; u1_a_be = '0; u1_b_be = '0;
    u0_a_addr = '0; u0_b_addr = '0; u1_a_addr = '0; u1_b_addr = '0;
    u0_a_wdata = '0; u0_b_wdata = '0; u1_a_wdata = '0; u1_b_wdata = '0;
    @(negedge clk);
    reset_pulse();
`ifdef SRAM_DP_CLEAR_EN
    wait_clear();
    rd(0, 5, '0); step(); step();
`endif
    // Byte-enable write, then same-cycle reads on both ports.
    wr(0, 3, Ones, BeAll); step();
    wr(0, 3, '0, 64'h1); step();
    rd(0, 3, ExpBe); rd(1, 3, ExpBe); step();
    // Same-address write/write collision.
    wr(0, 10, PatAa, BeLo); wr(1, 10, Pat55, BeAll); cq0.push_back(cyc + 1); step();
    rd(0, 10, ExpC); step(); step();
    chk("rdata_hold", u0_a_rdata, ExpC);
    chk1("rvalid_idle", u0_a_rvalid, 1'b0);
    // Read-first across ports, then back-to-back read of the new data.
    wr(0, 20, 512'h1234, BeAll); step();
    rd(0, 20, 512'h1234); wr(1, 20, 512'h5678, BeAll); step();
    rd(0, 20, 512'h5678); step();
    // Two-cycle latency, out-of-range write discarded and reads return zero.
    wr(2, 98, H98, BeAll); wr(3, 99, H99, BeAll); step();
    wr(2, 100, 512'hDEAD, BeAll); step();
    rd(3, 98, H98); step();
    rd(3, 99, H99); step();
    rd(3, 100, '0); step();
    rd(3, 101, '0); step();
    repeat (3) step();
    wr(2, 50, 512'h11, 64'h1); wr(3, 50, PatEe, BeAll); cq1.push_back(cyc + 1); step();
    rd(2, 50, ExpC1); step();
    repeat (3) step();
    // Reset while reads are in flight on both pipeline depths.
    drv(0, 1'b0, 3, '0, '0); drv(3, 1'b0, 98, '0, '0);
    @(posedge clk); #1;
    chk1("rvalid_before_reset", u0_a_rvalid, 1'b1);
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("no_stale_rvalid_u1", u1_b_rvalid, 1'b0);
    end
`ifdef SRAM_DP_CLEAR_EN
    wait_clear();
    rd(0, 3, '0); step(); step();
    // Reset 40 cycles into a clear while reads are being attempted.
    reset_pulse();
    for (int i = 0; i < 40; i++) begin
      drv(0, 1'b0, 5, '0, '0); drv(3, 1'b0, 5, '0, '0);
      step();
    end
    reset_pulse();
    wait_clear();
    rd(0, 20, '0); step(); step();
`else
    rd(0, 3, ExpBe); step(); step();
`endif
    repeat (4) step();
    chk("queues_drained", DW'(q0.size() + q1.size() + q2.size() + q3.size()
                              + cq0.size() + cq1.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
